// File: rtl/load_extend_unit.sv
// load_extend_unit: word-aligned memory reads for byte/half/word loads, sign- or zero-extended result.
// Define LOAD_UNALIGNED_EN to accept any address; word-crossing loads then take a second read.
module load_extend_unit (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic [31:0] Addr,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic [31:0] MemRData,
  input  logic        MemReady,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] RData,
  output logic        Err
);
`ifdef LOAD_UNALIGNED_EN
  typedef enum logic [1:0] {IDLE, REQ0, REQ1, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ0, DONE} state_t;
`endif
  state_t state_q, state_d;
  logic [1:0] off_q, off_d, size_q, size_d;
  logic uns_q, uns_d, mem_req_q, mem_req_d, busy_q, busy_d, done_q, done_d, err_q, err_d, fin, bad;
  logic [31:0] mem_addr_q, mem_addr_d, rdata_q, rdata_d, sh;
  logic [63:0] src;
`ifdef LOAD_UNALIGNED_EN
  logic [31:0] word0_q, word0_d;
  logic cross;
  assign bad = Size == 2'b11;
  assign cross = (size_q == 2'b01 && off_q == 2'b11) || (size_q == 2'b10 && off_q != 2'b00);
`else
  assign bad = Size == 2'b11 || (Size == 2'b01 && Addr[0]) || (Size == 2'b10 && Addr[1:0] != 2'b00);
`endif
  always_comb begin
    state_d = state_q;
    off_d = off_q;
    size_d = size_q;
    uns_d = uns_q;
    mem_addr_d = mem_addr_q;
    rdata_d = rdata_q;
    err_d = err_q;
    fin = 1'b0;
    src = {32'd0, MemRData};
`ifdef LOAD_UNALIGNED_EN
    word0_d = word0_q;
`endif
    case (state_q)
      IDLE: if (Start) begin
        off_d = Addr[1:0];
        size_d = Size;
        uns_d = Unsigned;
        state_d = bad ? DONE : REQ0;
        mem_addr_d = bad ? mem_addr_q : {Addr[31:2], 2'b00};
        if (bad) begin
          err_d = 1'b1;
          rdata_d = 32'd0;
        end
      end
      REQ0: if (MemReady) begin
`ifdef LOAD_UNALIGNED_EN
        word0_d = MemRData;
        state_d = cross ? REQ1 : DONE;
        mem_addr_d = mem_addr_q + {29'd0, cross, 2'b00};
        fin = !cross;
`else
        state_d = DONE;
        fin = 1'b1;
`endif
      end
`ifdef LOAD_UNALIGNED_EN
      REQ1: if (MemReady) begin
        state_d = DONE;
        src = {MemRData, word0_q};
        fin = 1'b1;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // lanes arrive in ascending address order, so the offset is a plain right shift
    sh = 32'(src >> {off_q, 3'b000});
    if (fin) begin
      rdata_d = size_q == 2'b00 ? {{24{sh[7] & !uns_q}}, sh[7:0]} :
                size_q == 2'b01 ? {{16{sh[15] & !uns_q}}, sh[15:0]} : sh;
      err_d = 1'b0;
    end
    mem_req_d = state_d != IDLE && state_d != DONE;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      off_q <= 2'd0;
      size_q <= 2'd0;
      uns_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_addr_q <= 32'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q <= 1'b0;
`ifdef LOAD_UNALIGNED_EN
      word0_q <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      off_q <= off_d;
      size_q <= size_d;
      uns_q <= uns_d;
      mem_req_q <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      busy_q <= busy_d;
      done_q <= done_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
`ifdef LOAD_UNALIGNED_EN
      word0_q <= word0_d;
`endif
    end
  end
  assign MemReq = mem_req_q;
  assign MemAddr = mem_addr_q;
  assign Busy = busy_q;
  assign Done = done_q;
  assign RData = rdata_q;
  assign Err = err_q;
endmodule

// File: tb/tb_load_extend_unit.sv
// tb_load_extend_unit: directed and random loads against a byte-level memory model with variable wait states.
module tb_load_extend_unit;
  logic Clk = 1'b0, Rst_n = 1'b0, Start = 1'b0, Unsigned = 1'b0, MemReady = 1'b0;
  logic MemReq, Busy, Done, Err;
  logic [31:0] Addr = 32'd0, MemRData = 32'd0, MemAddr, RData;
  logic [1:0] Size = 2'd0;
  int n_tests = 0, n_fail = 0, wait_cyc = 0, cnt = 0;
  logic [31:0] rd_q[$];
  always #5 Clk = ~Clk;
  load_extend_unit dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Addr(Addr), .Size(Size), .Unsigned(Unsigned),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemRData(MemRData), .MemReady(MemReady),
    .Busy(Busy), .Done(Done), .RData(RData), .Err(Err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h80FF7F01;
    if (a == 32'h104) return 32'h12345678;
    return (a * 32'h9E3779B1) ^ 32'h5BD1E995;
  endfunction
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w = mem_word({a[31:2], 2'b00});
    return w[8 * a[1:0] +: 8];
  endfunction
  task automatic model(input logic [31:0] a, input logic [1:0] sz, input logic u,
                       output logic [31:0] v, output logic e, output int nr);
    int n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    logic [31:0] mask;
    v = 32'd0;
    e = 1'b0;
    nr = 0;
    if (sz == 2'd3) begin
      e = 1'b1;
      return;
    end
`ifndef LOAD_UNALIGNED_EN
    if (a % n != 0) begin
      e = 1'b1;
      return;
    end
`endif
    for (int i = 0; i < n; i++) v[8 * i +: 8] = mem_byte(a + 32'(i));
    mask = (n == 4) ? 32'hFFFFFFFF : (32'd1 << (8 * n)) - 32'd1;
    if (!u && v[8 * n - 1]) v = v | ~mask;
    nr = (int'(a[1:0]) + n > 4) ? 2 : 1;
  endtask
  always @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt = 0;
      MemReady = 1'b0;
    end else begin
      if (MemReady) cnt = 0;
      MemReady = 1'b0;
      if (MemReq) begin
        if (cnt >= wait_cyc) begin
          MemReady = 1'b1;
          MemRData = mem_word(MemAddr);
          rd_q.push_back(MemAddr);
        end else cnt++;
      end
    end
  end
  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic u, input int w, input bit poke);
    logic [31:0] ev, a0;
    logic ee;
    int nr, lat, exp_lat, mreq;
    model(a, sz, u, ev, ee, nr);
    exp_lat = ee ? 1 : 1 + nr * (1 + w);
    a0 = {a[31:2], 2'b00};
    wait_cyc = w;
    rd_q.delete();
    @(negedge Clk);
    Addr = a; Size = sz; Unsigned = u; Start = 1'b1;
    @(posedge Clk); #1;
    Start = poke; Addr = ~a; Size = ~sz; Unsigned = ~u;
    lat = 1;
    mreq = 0;
    while (!Done && lat < 60) begin
      mreq += int'(MemReq);
      @(posedge Clk); #1;
      lat++;
    end
    mreq += int'(MemReq);
    Start = 1'b0;
    check("done", 32'(Done), 32'd1);
    check("busy_at_done", 32'(Busy), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("rdata", RData, ev);
    check("err", 32'(Err), 32'(ee));
    check("reads", 32'(rd_q.size()), 32'(nr));
    check("memreq_cycles", 32'(mreq), 32'(nr * (1 + w)));
    if (rd_q.size() > 0) check("addr0", rd_q[0], a0);
    if (rd_q.size() > 1) check("addr1", rd_q[1], a0 + 32'd4);
    @(posedge Clk); #1;
    check("idle_busy", 32'(Busy), 32'd0);
    check("done_pulse", 32'(Done), 32'd0);
  endtask
  initial begin
    repeat (2) @(posedge Clk);
    #1;
    check("rst_memreq", 32'(MemReq), 32'd0);
    check("rst_memaddr", MemAddr, 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_rdata", RData, 32'd0);
    check("rst_err", 32'(Err), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    do_load(32'h103, 2'd0, 1'b0, 0, 1'b0);
    do_load(32'h103, 2'd0, 1'b1, 0, 1'b0);
    do_load(32'h100, 2'd0, 1'b0, 0, 1'b0);
    do_load(32'h100, 2'd1, 1'b0, 0, 1'b0);
    do_load(32'h102, 2'd1, 1'b0, 0, 1'b0);
    do_load(32'h102, 2'd1, 1'b1, 0, 1'b0);
    do_load(32'h100, 2'd2, 1'b0, 3, 1'b1);
    do_load(32'h102, 2'd2, 1'b0, 0, 1'b0);
    do_load(32'h100, 2'd3, 1'b0, 0, 1'b0);
    do_load(32'h103, 2'd1, 1'b0, 1, 1'b0);
    do_load(32'h101, 2'd2, 1'b1, 2, 1'b1);
    do_load(32'hFFFFFFFE, 2'd2, 1'b0, 0, 1'b0);
    do_load(32'h103, 2'd0, 1'b0, 0, 1'b0);
    // reset while REQ0 is stalled on MemReady
    wait_cyc = 10;
    @(negedge Clk);
    Addr = 32'h100; Size = 2'd2; Unsigned = 1'b0; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (2) @(posedge Clk);
    #3;
    Rst_n = 1'b0;
    #1;
    check("mid_rst_memreq", 32'(MemReq), 32'd0);
    check("mid_rst_memaddr", MemAddr, 32'd0);
    check("mid_rst_busy", 32'(Busy), 32'd0);
    check("mid_rst_done", 32'(Done), 32'd0);
    check("mid_rst_rdata", RData, 32'd0);
    check("mid_rst_err", 32'(Err), 32'd0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      check("post_rst_done", 32'(Done), 32'd0);
      check("post_rst_memreq", 32'(MemReq), 32'd0);
    end
    do_load(32'h101, 2'd0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'h100 + 32'($urandom_range(0, 15));
      do_load(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/load_extend_unit.md
# load_extend_unit

Load-side counterpart of the store width mux: it takes a load request (byte, halfword or word, signed or unsigned) from the MEM stage and issues word-aligned reads to data memory over a req/ready handshake. It extracts the addressed byte lanes, sign- or zero-extends them to 32 bits, and returns a registered result with a one-cycle `Done` pulse. The MEM-stage controller stalls the pipeline while `Busy` is high.

## Interface
- No parameters; data and address width fixed at 32.
- `Clk` — input, 1 — system clock; all state updates on its rising edge.
- `Rst_n` — input, 1 — reset, asynchronous assert, active-low.
- `Start` — input, 1 — load request; accepted only when `Busy`=0.
- `Addr` — input, 32 — byte address of the load.
- `Size` — input, 2 — width code: 00 byte, 01 halfword, 10 word, 11 reserved. Same encoding as the store mux select.
- `Unsigned` — input, 1 — 1 means zero-extend, 0 means sign-extend. Ignored for word loads.
- `MemReq` — output, 1 — memory read request.
- `MemAddr` — output, 32 — word-aligned read address; `[1:0]` is always 00.
- `MemRData` — input, 32 — read data; valid in the cycle `MemReady`=1.
- `MemReady` — input, 1 — memory has accepted the request and returned data this cycle.
- `Busy` — output, 1 — a request is in flight; high from the cycle after `Start` is accepted until `Done`.
- `Done` — output, 1 — single-cycle pulse; `RData` and `Err` are valid in this cycle.
- `RData` — output, 32 — extended load result; held until the next `Done`.
- `Err` — output, 1 — reserved size code, or an unsupported misalignment.

## Operation
- **Byte lanes are little-endian.** Byte k of a word is bits `[8k+7:8k]`. A halfword at offset k occupies bytes k and k+1.
- **State machine:** IDLE, REQ0, REQ1, DONE.
- **Start handling:**
  - `Start` in IDLE latches `Addr`, `Size` and `Unsigned`.
  - Size=11 goes directly to DONE with `Err`=1 and `RData`=0; no memory access is made.
  - An unsupported misalignment behaves the same way (see Configuration).
  - All other requests go to REQ0.
  - `Start` while `Busy`=1 is ignored.
- **REQ0:**
  - Drives `MemReq`=1 and `MemAddr`={Addr[31:2],2'b00}.
  - Holds both until `MemReady`=1, then captures `MemRData` as word0.
  - Goes to REQ1 if the access crosses a word boundary, otherwise to DONE.
- **REQ1:**
  - Drives `MemAddr`=word0 address + 4.
  - Captures word1 on `MemReady`, then goes to DONE.
- **DONE:**
  - Asserts `Done` for one cycle and returns to IDLE.
  - `RData` is updated in this same cycle.
  - A `Start` that arrives while in DONE is ignored.
- **Extraction:**
  - Assemble the bytes from word0 (and word1 for crossing accesses) in ascending address order.
  - Byte results extend bit 7; halfword results extend bit 15.
  - Width arithmetic is purely bit-select; no adders except the +4 address increment.
  - The address increment wraps modulo 2^32: word 0xFFFFFFFC + 4 gives 0x00000000.
- **Reset values:** `MemReq`=0, `MemAddr`=0, `Busy`=0, `Done`=0, `RData`=0, `Err`=0, state IDLE.
- **Reset mid-operation:** `Rst_n` low drops `MemReq` immediately (asynchronously) and discards the request. No `Done` is produced for it.

## Timing
- `Start` sampled at edge N; `MemReq` is high from cycle N+1.
- `MemReady` is sampled at each edge while `MemReq`=1; zero-wait memory returns `MemReady` in the same cycle as the request.
- Aligned load with zero-wait memory: `Done` at cycle N+2.
- Each memory wait cycle adds one cycle of latency.
- A crossing access adds one request phase plus that phase's wait cycles.
- Error path (reserved size or unsupported misalignment): `Done` at N+1 with no `MemReq`.
- `Busy` equals (state != IDLE).
- `MemAddr` and `MemReq` are registered outputs and remain stable while waiting for `MemReady`.

## Configuration
- Macro: `LOAD_UNALIGNED_EN`.
- **Defined:**
  - Any address is legal.
  - Halfword at offset 0–2, or word at offset 0: one read.
  - Halfword at offset 3, or word at offset 1–3: two reads (REQ0 then REQ1), merged as above.
- **Undefined:**
  - Halfword with `Addr[0]`=1 → `Err`=1, `RData`=0, no memory access.
  - Word with `Addr[1:0]`≠0 → same.
  - The REQ1 state is not built.

## Test plan
Memory contents for all cases: word 0x100 = 0x80FF7F01, word 0x104 = 0x12345678, zero-wait unless stated.

1. **Byte loads.** Byte 0x103 signed → `RData`=0xFFFFFF80; byte 0x103 unsigned → 0x00000080; byte 0x100 signed → 0x00000001. Each `Done` at N+2, `MemAddr`=0x100.
2. **Halfword loads.** Halfword 0x100 signed → 0x00007F01; halfword 0x102 signed → 0xFFFF80FF; halfword 0x102 unsigned → 0x000080FF.
3. **Word load with waits.** Word 0x100 with `MemReady` delayed 3 cycles → `MemReq`/`MemAddr` stable for 4 cycles, `Done` at N+5, `RData`=0x80FF7F01. A `Start` pulsed while `Busy` is ignored.
4. **Misaligned word.** Word 0x102:
   - With `LOAD_UNALIGNED_EN`: reads at 0x100 then 0x104, `RData`=0x567880FF, `Done` at N+3.
   - Without: `Err`=1, `RData`=0, `Done` at N+1, `MemReq` never asserted.
5. **Reserved size.** Size=11 at 0x100 → `Err`=1, `RData`=0, `Done` at N+1, no `MemReq`.
6. **Reset during wait.** `Rst_n` low during REQ0 while waiting for `MemReady` → `MemReq`=0 immediately, all outputs at reset values, no `Done`. A new byte 0x101 load after release → `RData`=0x0000007F.
